grf_mp: RTL and testbench

- Parametrised successor to the single-write GRF in the CPU datapath.
- Provides DEPTH = 2^ADDR_W registers of DATA_W bits, NUM_RD combinational read ports and two write ports with fixed priority.
- Optional write-to-read bypass.
- A sequential clear engine zeroes the whole file, one entry per cycle, on request (context flush or test).

---
 rtl/grf_mp_pkg.sv | 16 +
 rtl/grf_rd_mux.sv | 42 ++++
 rtl/grf_mp.sv | 151 +++++++++++++++
 tb/tb_grf_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_mp_pkg.sv
// Shared defaults, clear-engine state encoding and trace format for the
// multi-port general register file.
package grf_mp_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // Arguments: writer PC, register index, written data
  localparam string GRF_TRACE_FMT = "@%08h: $%0d <= %08h";

endpackage

// File: rtl/grf_rd_mux.sv
// One combinational read port: zero-register masking, then younger/older
// writer bypass, then the stored entry.
module grf_rd_mux
  import grf_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [DATA_W-1:0] entry,
  output logic [DATA_W-1:0] rd_c
);

  logic hit0_c;
  logic hit1_c;
  logic is_zero_c;

  // Port 1 is the younger writer, so it outranks port 0 on the bypass path
  always_comb begin
    hit1_c    = (BYPASS != 0) && !busy && we1 && (wa1 == ra);
    hit0_c    = (BYPASS != 0) && !busy && we0 && (wa0 == ra);
    is_zero_c = (ZERO_REG != 0) && (ra == '0);
    rd_c      = entry;
    if (is_zero_c) begin
      rd_c = '0;
    end else if (hit1_c) begin
      rd_c = wd1;
    end else if (hit0_c) begin
      rd_c = wd0;
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file: two prioritised write ports, NUM_RD
// combinational read ports with optional bypass, and a one-entry-per-cycle clear sweep.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WA0,
  input  logic [DATA_W-1:0]        WD0,
  input  logic [31:0]              WPC0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WA1,
  input  logic [DATA_W-1:0]        WD1,
  input  logic [31:0]              WPC1,
  input  logic                     Clr_req,
  output logic                     Busy,
  output logic                     Clr_done
);

  localparam int unsigned         DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  clr_state_e        state_q;
  clr_state_e        state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              done_q;
  logic              done_d;
  logic              busy;
  logic              wr0_c;
  logic              wr1_c;

  assign busy     = (state_q == SWEEP);
  assign Busy     = busy;
  assign Clr_done = done_q;

  // A write commits only while idle and never to a hardwired-zero entry
  always_comb begin
    wr0_c = WE0 && !busy && !((ZERO_REG != 0) && (WA0 == '0));
    wr1_c = WE1 && !busy && !((ZERO_REG != 0) && (WA1 == '0));
  end

  // Clear engine state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Clear engine next state; the pointer stops on LAST rather than wrapping
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage; port 1 is assigned last so it wins a same-address conflict
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (wr0_c) begin
        mem_q[WA0] <= WD0;
      end
      if (wr1_c) begin
        mem_q[WA1] <= WD1;
      end
    end
  end

`ifndef SYNTHESIS
  // Commit trace, port 0 before port 1
  always_ff @(posedge Clock) begin
    if (Reset_n) begin
      if (wr0_c) begin
        $display("%s", $sformatf(GRF_TRACE_FMT, WPC0, WA0, WD0));
      end
      if (wr1_c) begin
        $display("%s", $sformatf(GRF_TRACE_FMT, WPC1, WA1, WD1));
      end
    end
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;

    assign ra_i = RA[i*ADDR_W +: ADDR_W];

    grf_rd_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd_mux (
      .ra   (ra_i),
      .busy (busy),
      .we0  (WE0),
      .wa0  (WA0),
      .wd0  (WD0),
      .we1  (WE1),
      .wa1  (WA1),
      .wd1  (WD1),
      .entry(mem_q[ra_i]),
      .rd_c (RD[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: a bypassing and a non-bypassing instance
// share stimulus; expectations flow through a scoreboard queue.
module tb_grf_mp;
  import grf_mp_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic [NR*AW-1:0]  RA;
  logic [NR*DW-1:0]  RD;
  logic [NR*DW-1:0]  RD_nb;
  logic              WE0, WE1, Clr_req;
  logic [AW-1:0]     WA0, WA1;
  logic [DW-1:0]     WD0, WD1;
  logic [31:0]       WPC0, WPC1;
  logic              Busy, Clr_done, Busy_nb, Clr_done_nb;

  always #5 Clock = ~Clock;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .RA(RA), .RD(RD),
    .WE0(WE0), .WA0(WA0), .WD0(WD0), .WPC0(WPC0),
    .WE1(WE1), .WA1(WA1), .WD1(WD1), .WPC1(WPC1),
    .Clr_req(Clr_req), .Busy(Busy), .Clr_done(Clr_done)
  );

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .Clock(Clock), .Reset_n(Reset_n), .RA(RA), .RD(RD_nb),
    .WE0(WE0), .WA0(WA0), .WD0(WD0), .WPC0(WPC0),
    .WE1(WE1), .WA1(WA1), .WD1(WD1), .WPC1(WPC1),
    .Clr_req(Clr_req), .Busy(Busy_nb), .Clr_done(Clr_done_nb)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] enb;
  } vec_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   miscompares = 0;
  vec_t tbl[10];

  task automatic expect_v(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic compare_v(input logic [31:0] act);
    exp_t e;
    vec_cnt++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got %h", act);
      return;
    end
    e = sb_q.pop_front();
    if (act !== e.val) begin
      miscompares++;
      $display("FAIL %s got %h want %h", e.name, act, e.val);
    end
  endtask

  function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] enb);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.enb = enb;
    return v;
  endfunction

  task automatic idle_inputs();
    WE0 = 1'b0; WA0 = '0; WD0 = '0; WPC0 = 32'h0;
    WE1 = 1'b0; WA1 = '0; WD1 = '0; WPC1 = 32'h0;
    Clr_req = 1'b0;
  endtask

  // Pulse Clr_req, then observe 40 cycles; probe adds mid-sweep reads/writes
  task automatic run_sweep(input bit probe, output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    Clr_req = 1'b1;
    @(negedge Clock);
    Clr_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Busy) busy_cnt++;
      if (Clr_done) done_cnt++;
      if (c == 33) begin
        expect_v("clr_done_after_last", 32'd1);
        compare_v(32'(Clr_done));
      end
      if (probe) begin
        idle_inputs();
        if (c == 5) begin
          RA = {5'd10, 5'd2};
          WE0 = 1'b1; WA0 = 5'd7;  WD0 = 32'h77;   WPC0 = 32'h500;
          WE1 = 1'b1; WA1 = 5'd10; WD1 = 32'hDEAD; WPC1 = 32'h504;
          expect_v("sweep_swept_ra2", 32'd0);
          expect_v("sweep_unswept_ra10_nobypass", 32'd10);
          #1;
          compare_v(RD[31:0]);
          compare_v(RD[63:32]);
        end
        if (c == 6) begin
          RA = {5'd10, 5'd7};
          expect_v("sweep_dropped_wr7", 32'd7);
          expect_v("sweep_dropped_wr10", 32'd10);
          #1;
          compare_v(RD[31:0]);
          compare_v(RD[63:32]);
        end
        if (c == 8) Clr_req = 1'b1;
      end
      @(negedge Clock);
    end
    idle_inputs();
  endtask

  initial begin
    int bc;
    int dc;
    Reset_n = 1'b0;
    RA = '0;
    idle_inputs();

    tbl[0] = mk(0, 0, 0,          0, 0, 0,             0, 31, 0,            0,            0);
    tbl[1] = mk(1, 5, 32'h1234,   1, 5, 32'hBEEF,      5, 5,  32'hBEEF,     32'hBEEF,     0);
    tbl[2] = mk(0, 0, 0,          0, 0, 0,             5, 0,  32'hBEEF,     0,            32'hBEEF);
    tbl[3] = mk(0, 0, 0,          1, 0, 32'hFFFFFFFF,  0, 0,  0,            0,            0);
    tbl[4] = mk(0, 0, 0,          0, 0, 0,             0, 0,  0,            0,            0);
    tbl[5] = mk(1, 3, 32'hA5,     0, 0, 0,             3, 3,  32'hA5,       32'hA5,       0);
    tbl[6] = mk(0, 0, 0,          0, 0, 0,             3, 3,  32'hA5,       32'hA5,       32'hA5);
    tbl[7] = mk(1, 3, 32'h11,     1, 4, 32'h22,        3, 4,  32'h11,       32'h22,       32'hA5);
    tbl[8] = mk(0, 0, 0,          0, 0, 0,             3, 4,  32'h11,       32'h22,       32'h11);
    tbl[9] = mk(1, 4, 32'h33,     1, 9, 32'h99,        4, 9,  32'h33,       32'h99,       32'h22);

    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    // Reset state of every entry on both ports
    for (int a = 0; a < 32; a++) begin
      RA = {5'(a), 5'(a)};
      expect_v($sformatf("reset_rd0_a%0d", a), 32'd0);
      expect_v($sformatf("reset_rd1_a%0d", a), 32'd0);
      #1;
      compare_v(RD[31:0]);
      compare_v(RD[63:32]);
    end
    expect_v("reset_busy", 32'd0);
    expect_v("reset_clr_done", 32'd0);
    compare_v(32'(Busy));
    compare_v(32'(Clr_done));
    @(negedge Clock);

    for (int i = 0; i < 10; i++) begin
      WE0 = tbl[i].we0; WA0 = tbl[i].wa0; WD0 = tbl[i].wd0; WPC0 = 32'h100 + 32'(i * 8);
      WE1 = tbl[i].we1; WA1 = tbl[i].wa1; WD1 = tbl[i].wd1; WPC1 = 32'h104 + 32'(i * 8);
      RA = {tbl[i].ra1, tbl[i].ra0};
      expect_v($sformatf("vec%0d_rd0", i), tbl[i].e0);
      expect_v($sformatf("vec%0d_rd1", i), tbl[i].e1);
      expect_v($sformatf("vec%0d_nobypass_rd0", i), tbl[i].enb);
      #1;
      compare_v(RD[31:0]);
      compare_v(RD[63:32]);
      compare_v(RD_nb[31:0]);
      @(negedge Clock);
    end
    idle_inputs();

    // Fill entries 1..31 with their index, then sweep with mid-sweep probes
    for (int a = 1; a < 32; a++) begin
      WE0 = 1'b1; WA0 = 5'(a); WD0 = 32'(a); WPC0 = 32'h200 + 32'(a * 4);
      @(negedge Clock);
    end
    idle_inputs();
    run_sweep(1'b1, bc, dc);
    expect_v("sweep1_busy_cycles", 32'd32);
    expect_v("sweep1_done_pulses", 32'd1);
    compare_v(32'(bc));
    compare_v(32'(dc));
    for (int a = 0; a < 32; a++) begin
      RA = {5'(a), 5'(a)};
      expect_v($sformatf("post_sweep_a%0d", a), 32'd0);
      #1;
      compare_v(RD[31:0]);
    end
    @(negedge Clock);

    // Reset in the middle of a sweep (pointer = 12)
    WE0 = 1'b1; WA0 = 5'd13; WD0 = 32'h13;  WPC0 = 32'h300;
    WE1 = 1'b1; WA1 = 5'd20; WD1 = 32'hABC; WPC1 = 32'h304;
    @(negedge Clock);
    idle_inputs();
    Clr_req = 1'b1;
    @(negedge Clock);
    Clr_req = 1'b0;
    repeat (12) @(negedge Clock);
    RA = {5'd13, 5'd20};
    expect_v("pre_abort_busy", 32'd1);
    expect_v("pre_abort_ra20", 32'hABC);
    expect_v("pre_abort_ra13", 32'h13);
    #1;
    compare_v(32'(Busy));
    compare_v(RD[31:0]);
    compare_v(RD[63:32]);
    #1;
    Reset_n = 1'b0;
    #1;
    expect_v("abort_busy", 32'd0);
    expect_v("abort_ra20", 32'd0);
    expect_v("abort_ra13", 32'd0);
    compare_v(32'(Busy));
    compare_v(RD[31:0]);
    compare_v(RD[63:32]);
    @(negedge Clock);
    Reset_n = 1'b1;
    bc = 0;
    for (int c = 0; c < 25; c++) begin
      if (Clr_done || Busy) bc++;
      @(negedge Clock);
    end
    expect_v("abort_no_done_or_busy", 32'd0);
    compare_v(32'(bc));

    run_sweep(1'b0, bc, dc);
    expect_v("sweep2_busy_cycles", 32'd32);
    expect_v("sweep2_done_pulses", 32'd1);
    compare_v(32'(bc));
    compare_v(32'(dc));

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
